// File: rtl/led_scan_controller.sv
// led_scan_controller
// Column-scanning driver for an N x N Conway-grid LED matrix. Each column is
// enabled for DWELL_TICKS cycles; a one-deep shadow buffer accepts new frames
// through a valid/ready handshake and is promoted to the displayed frame only
// at a frame boundary, so the picture never tears.
//
// Configuration macro: LED_SCAN_BLANKING_EN
//   defined   -> BLANK state inserts BLANK_TICKS enable-low cycles between
//                columns (frame period N*(DWELL_TICKS+BLANK_TICKS)).
//   undefined -> columns are driven back to back with ena held high
//                (frame period N*DWELL_TICKS).
module led_scan_controller #(
  parameter int N           = 5,
  parameter int DWELL_TICKS = 1000,
  parameter int BLANK_TICKS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                run,
  input  logic                frame_valid,
  input  logic [N*N-1:0]      frame_cells,
  output logic                frame_ready,
  output logic                ena,
  output logic [$clog2(N):0]  x,
  output logic [N*N-1:0]      cells,
  output logic                frame_done
);

  localparam int XW   = $clog2(N) + 1;
  localparam int MAXT = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int CW   = $clog2(MAXT) + 1;

  localparam logic [XW-1:0] LAST_X     = XW'(N - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_TICKS - 1);
`ifdef LED_SCAN_BLANKING_EN
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    BLANK
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [XW-1:0]   x_nxt, x_wrap;
  logic            ena_nxt, done_nxt;

  logic            shadow_full;
  logic [N*N-1:0]  shadow;
  logic            take;

  // Elaboration-time sanity check of the parameters.
  initial begin
    if (N < 1 || N > 8)
      $error("led_scan_controller: N=%0d outside 1..8", N);
    if (DWELL_TICKS < 1)
      $error("led_scan_controller: DWELL_TICKS=%0d must be >= 1", DWELL_TICKS);
    if (BLANK_TICKS < 1)
      $error("led_scan_controller: BLANK_TICKS=%0d must be >= 1", BLANK_TICKS);
  end

  // Column index after the current one, wrapping N-1 -> 0.
  assign x_wrap = (x == LAST_X) ? '0 : x + XW'(1);

  // State register; ena/x/frame_done are registered copies of next-state decode.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      x          <= '0;
      ena        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      x          <= x_nxt;
      ena        <= ena_nxt;
      frame_done <= done_nxt;
    end
  end

  // Next-state logic: dwell/blank timing and column advance.
  // NOTE: every output of this block gets a default first, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    x_nxt     = x;
    if (!run) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      x_nxt     = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = DRIVE;
          cnt_nxt   = '0;
          x_nxt     = '0;
        end
        DRIVE: begin
          if (cnt == DWELL_LAST) begin
            cnt_nxt = '0;
`ifdef LED_SCAN_BLANKING_EN
            state_nxt = BLANK;
`else
            x_nxt = x_wrap;
`endif
          end
        end
`ifdef LED_SCAN_BLANKING_EN
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state_nxt = DRIVE;
            cnt_nxt   = '0;
            x_nxt     = x_wrap;
          end
        end
`endif
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          x_nxt     = '0;
        end
      endcase
    end
  end

  // Output decode of the upcoming state; registered above so outputs are glitch-free.
  always_comb begin
    ena_nxt  = (state_nxt == DRIVE);
    done_nxt = (state_nxt == DRIVE) && (x_nxt == LAST_X) && (cnt_nxt == DWELL_LAST);
  end

  assign take = frame_valid && frame_ready;

  // Handshake and frame promotion: shadow -> active only while frame_done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_full <= 1'b0;
      frame_ready <= 1'b1;
      cells       <= '0;
    end else if (take) begin
      // A frame arriving on the frame_done cycle lands in the shadow only;
      // the shadow was empty, so there is nothing to promote this time.
      shadow_full <= 1'b1;
      frame_ready <= 1'b0;
    end else if (frame_done && shadow_full) begin
      shadow_full <= 1'b0;
      frame_ready <= 1'b1;
      cells       <= shadow;
    end
  end

  // Shadow frame storage.
  // NOTE: the data register has no reset; shadow_full qualifies it, so its
  // contents are never observed before a valid write.
  always_ff @(posedge clk) begin
    if (take) shadow <= frame_cells;
  end

endmodule

// File: tb/tb_led_scan_controller.sv
// tb_led_scan_controller
// Drives led_scan_controller (N=5, DWELL_TICKS=4, BLANK_TICKS=2) and compares
// every cycle against a timeline model of the scan plus a frame scoreboard:
// accepted frames are pushed when the handshake fires and popped into the
// expected display at each modelled frame boundary.
module tb_led_scan_controller;

  localparam int N  = 5;
  localparam int D  = 4;
  localparam int B  = 2;
`ifdef LED_SCAN_BLANKING_EN
  localparam int BL = B;
`else
  localparam int BL = 0;
`endif
  localparam int CYC = D + BL;
  localparam int P   = N * CYC;
  localparam int NN  = N * N;
  localparam int XW  = $clog2(N) + 1;

  localparam logic [NN-1:0] FRAME_A = 25'h1555555;
  localparam logic [NN-1:0] FRAME_B = 25'h0AAAAAA;
  localparam logic [NN-1:0] FRAME_C = 25'h0F0F0F0;
  localparam logic [NN-1:0] FRAME_D = 25'h1FFFFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic          frame_valid = 1'b0;
  logic [NN-1:0] frame_cells = '0;
  logic          frame_ready;
  logic          ena;
  logic [XW-1:0] x;
  logic [NN-1:0] cells;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit            running   = 1'b0;
  int            t         = 0;
  int            ph_now    = 0;
  logic          exp_ena   = 1'b0;
  logic          exp_done  = 1'b0;
  logic          exp_ready = 1'b1;
  logic [XW-1:0] exp_x     = '0;
  logic [NN-1:0] exp_cells = '0;
  logic [NN-1:0] sb[$];

  led_scan_controller #(
    .N(N),
    .DWELL_TICKS(D),
    .BLANK_TICKS(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .run(run),
    .frame_valid(frame_valid),
    .frame_cells(frame_cells),
    .frame_ready(frame_ready),
    .ena(ena),
    .x(x),
    .cells(cells),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected scan outputs from the position in the scan timeline.
  task automatic update_scan();
    int col;
    int ph;
    col      = (t / CYC) % N;
    ph       = t % CYC;
    ph_now   = ph;
    exp_ena  = running && (ph < D);
    exp_x    = running ? XW'(col) : '0;
    exp_done = running && (col == N - 1) && (ph == D - 1);
  endtask

  // One clock: advance the model, update the scoreboard, compare all outputs.
  task automatic tick();
    logic          pv, pr, pd, prun;
    logic [NN-1:0] pf;
    pv = frame_valid; pf = frame_cells; pr = exp_ready; pd = exp_done; prun = run;
    @(posedge clk);
    #1;
    if (prun) begin
      if (running) t++;
      else begin running = 1'b1; t = 0; end
    end else begin
      running = 1'b0;
    end
    update_scan();
    if (pv && pr) begin
      sb.push_back(pf);
      exp_ready   = 1'b0;
      frame_valid = 1'b0;
    end else if (pd && !exp_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_underflow: scoreboard empty at frame boundary t=%0d", t);
      end else begin
        exp_cells = sb.pop_front();
      end
      exp_ready = 1'b1;
    end
    total++;
    if (ena !== exp_ena) begin
      bad++; $display("FAIL ena t=%0d: got %b want %b", t, ena, exp_ena);
    end
    total++;
    if (x !== exp_x) begin
      bad++; $display("FAIL x t=%0d: got %0d want %0d", t, x, exp_x);
    end
    total++;
    if (frame_done !== exp_done) begin
      bad++; $display("FAIL frame_done t=%0d: got %b want %b", t, frame_done, exp_done);
    end
    total++;
    if (frame_ready !== exp_ready) begin
      bad++; $display("FAIL frame_ready t=%0d: got %b want %b", t, frame_ready, exp_ready);
    end
    total++;
    if (cells !== exp_cells) begin
      bad++; $display("FAIL cells t=%0d: got %h want %h", t, cells, exp_cells);
    end
  endtask

  task automatic reset_model();
    running   = 1'b0;
    t         = 0;
    sb.delete();
    exp_ready = 1'b1;
    exp_cells = '0;
    update_scan();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    total++; if (ena !== 1'b0) begin bad++; $display("FAIL reset_ena: got %b want 0", ena); end
    total++; if (x !== '0) begin bad++; $display("FAIL reset_x: got %0d want 0", x); end
    total++; if (cells !== '0) begin bad++; $display("FAIL reset_cells: got %h want 0", cells); end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", frame_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (frame_ready !== 1'b1 || ena !== 1'b0) begin
      bad++; $display("FAIL reset_hold: got ready=%b ena=%b want ready=1 ena=0", frame_ready, ena);
    end
    #2 rst = 1'b1;
    reset_model();
    repeat (3) tick();
  endtask

  task automatic test_scan();
    int first;
    int second;
    first  = -1;
    second = -1;
    run = 1'b1;
    for (int i = 0; i < 2 * P + 3; i++) begin
      tick();
      if (frame_done === 1'b1) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    total++;
    if (first < 0 || second < 0 || (second - first) != P) begin
      bad++; $display("FAIL done_period: got first=%0d second=%0d want spacing %0d", first, second, P);
    end
  endtask

  task automatic test_handshake();
    int n;
    n = 0;
    while (!(exp_x == 2 && exp_ena) && n < 4 * P) begin tick(); n++; end
    total++; if (n >= 4 * P) begin bad++; $display("FAIL hs_wait_col2: timeout after %0d cycles", n); end
    frame_cells = FRAME_A;
    frame_valid = 1'b1;
    tick();
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL hs_ready_low: got %b want 0", frame_ready); end
    frame_cells = FRAME_B;
    frame_valid = 1'b1;
    repeat (2 * P + 2) tick();
    total++; if (cells !== FRAME_B) begin bad++; $display("FAIL hs_second_frame: got %h want %h", cells, FRAME_B); end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL hs_ready_back: got %b want 1", frame_ready); end
  endtask

  task automatic test_coincide();
    int n;
    n = 0;
    while (!exp_done && n < P + 2) begin tick(); n++; end
    total++; if (n >= P + 2) begin bad++; $display("FAIL co_wait_done: timeout after %0d cycles", n); end
    frame_cells = FRAME_C;
    frame_valid = 1'b1;
    tick();
    total++; if (cells !== FRAME_B) begin bad++; $display("FAIL co_hold: got %h want %h", cells, FRAME_B); end
    total++; if (frame_ready !== 1'b0) begin bad++; $display("FAIL co_stored: got ready=%b want 0", frame_ready); end
    n = 0;
    while (!exp_done && n < P + 2) begin tick(); n++; end
    tick();
    total++; if (cells !== FRAME_C) begin bad++; $display("FAIL co_shown: got %h want %h", cells, FRAME_C); end
  endtask

  task automatic test_run_drop();
    int n;
    logic          want_ena;
    logic [XW-1:0] want_x;
    n = 0;
    while (!(exp_x == 3 && exp_ena) && n < 2 * P) begin tick(); n++; end
    total++; if (n >= 2 * P) begin bad++; $display("FAIL rd_wait_col3: timeout after %0d cycles", n); end
    run = 1'b0;
    tick();
    total++; if (ena !== 1'b0 || x !== '0) begin
      bad++; $display("FAIL rd_idle: got ena=%b x=%0d want ena=0 x=0", ena, x);
    end
    run = 1'b1;
    for (int i = 0; i < D; i++) begin
      tick();
      total++; if (ena !== 1'b1 || x !== '0) begin
        bad++; $display("FAIL rd_col0 cycle=%0d: got ena=%b x=%0d want ena=1 x=0", i, ena, x);
      end
    end
    want_ena = (BL == 0);
    want_x   = (BL == 0) ? XW'(1) : '0;
    tick();
    total++; if (ena !== want_ena || x !== want_x) begin
      bad++; $display("FAIL rd_after_col0: got ena=%b x=%0d want ena=%b x=%0d", ena, x, want_ena, want_x);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!(exp_x == 1 && exp_ena && ph_now == 0) && n < 2 * P) begin tick(); n++; end
    total++; if (n >= 2 * P) begin bad++; $display("FAIL ar_wait_col1: timeout after %0d cycles", n); end
    frame_cells = FRAME_D;
    frame_valid = 1'b1;
    tick();
    #2 rst = 1'b0;
    #1;
    total++; if (ena !== 1'b0) begin bad++; $display("FAIL ar_ena: got %b want 0", ena); end
    total++; if (x !== '0) begin bad++; $display("FAIL ar_x: got %0d want 0", x); end
    total++; if (cells !== '0) begin bad++; $display("FAIL ar_cells: got %h want 0", cells); end
    total++; if (frame_ready !== 1'b1) begin bad++; $display("FAIL ar_ready: got %b want 1", frame_ready); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL ar_done: got %b want 0", frame_done); end
    frame_valid = 1'b0;
    reset_model();
    rst = 1'b1;
    repeat (2 * P) tick();
    total++; if (cells !== '0) begin bad++; $display("FAIL ar_discard: got %h want 0", cells); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_handshake();
    test_coincide();
    test_run_drop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_scan_controller.md
LED_SCAN_CONTROLLER -- requirements
Module: led_scan_controller

Interface
REQ-001 The block SHALL provide parameter N, default 5, meaning Conway grid edge length; legal values are 1..8.
REQ-002 The block SHALL provide parameter DWELL_TICKS, default 1000, meaning clock cycles each column is driven; minimum 1.
REQ-003 The block SHALL provide parameter BLANK_TICKS, default 16, meaning ena-low cycles between columns; minimum 1.
REQ-004 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  is the reset; it is asynchronous and active-low.
REQ-006 run  input  1  enables scanning while high.
REQ-007 frame_valid  input  1  indicates frame_cells holds a new frame.
REQ-008 frame_cells  input  N*N  is the new frame; bit r*N+c is row r, column c.
REQ-009 frame_ready  output  1  indicates the shadow buffer can accept a frame.
REQ-010 ena  output  1  is the column decoder enable.
REQ-011 x  output  $clog2(N)+1  is the column index to the decoder.
REQ-012 cells  output  N*N  is the active frame presented to the row logic.
REQ-013 frame_done  output  1  is a one-cycle pulse at end of each scanned frame.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, BLANK; all outputs are registered.
REQ-015 In IDLE: ena=0, x=0, dwell counter=0; when run=1 the next state is DRIVE with x=0.
REQ-016 In DRIVE: ena=1 for exactly DWELL_TICKS cycles, then transition to BLANK (macro defined) or advance x directly in DRIVE (macro undefined).
REQ-017 In BLANK: ena=0, x holds, for exactly BLANK_TICKS cycles, then DRIVE with x incremented.
REQ-018 x SHALL count 0..N-1 and wrap from N-1 to 0; it never takes values >= N.
REQ-019 frame_done SHALL pulse high for one cycle on the last DWELL cycle of column N-1.
REQ-020 Handshake: a frame transfers into the shadow buffer on a rising edge where frame_valid=1 and frame_ready=1; frame_ready then goes 0 the following cycle.
REQ-021 frame_ready SHALL be registered as NOT shadow_full; frame_valid while frame_ready=0 is ignored and the sender holds it.
REQ-022 On the cycle frame_done is high, a full shadow SHALL copy into the active buffer (cells updates the next cycle) and shadow_full clears, so frame_ready=1 the next cycle.
REQ-023 If frame_valid=1, frame_ready=1 and frame_done=1 coincide, the frame is stored in the shadow only and is displayed after the following frame_done.
REQ-024 cells SHALL never change mid-frame (no tearing).
REQ-025 run deasserted in any state SHALL force IDLE on the next edge (ena=0, x=0); the shadow contents and handshake are unaffected.
REQ-026 The dwell/blank counter SHALL be $clog2(max(DWELL_TICKS,BLANK_TICKS))+1 bits wide and reset to 0 on every state change.
REQ-027 An initial-block $error SHALL fire for N outside 1..8 or for DWELL_TICKS<1 or BLANK_TICKS<1.

Reset
REQ-028 rst low SHALL immediately force: state IDLE, ena=0, x=0, cells=0, shadow empty, frame_ready=1, frame_done=0, counter=0.
REQ-029 Reset asserted mid-operation SHALL discard any pending shadow frame; scanning restarts at column 0 once rst is high and run is 1.

Configuration
REQ-030 Macro LED_SCAN_BLANKING_EN defined: BLANK state is present with BLANK_TICKS inter-column blanking, giving a frame period of N*(DWELL_TICKS+BLANK_TICKS) cycles.
REQ-031 LED_SCAN_BLANKING_EN undefined: BLANK state and BLANK_TICKS are unused, ena stays 1 throughout a scan, and the frame period is N*DWELL_TICKS cycles.

Verification (N=5, DWELL_TICKS=4, BLANK_TICKS=2)
REQ-032 Reset, then run=1 with blanking enabled -> x=0..4, each with ena=1 for 4 cycles, then 2 cycles ena=0; frame_done pulses every 30 cycles; x wraps to 0.
REQ-033 frame_valid=1 with frame_cells=25'h1555555 during column 2 -> accepted, frame_ready=0 next cycle, cells unchanged until the cycle after frame_done, then cells=25'h1555555 and frame_ready=1.
REQ-034 Second frame 25'h0AAAAAA held valid while frame_ready=0 -> not accepted until frame_ready returns to 1; it is displayed one frame later.
REQ-035 run dropped during column 3 DRIVE -> next cycle ena=0, x=0; run reasserted -> column 0 is driven for a full 4 cycles.
REQ-036 rst pulsed low asynchronously (between edges) mid-DRIVE with a pending shadow frame -> ena, x, cells go to 0 and frame_ready goes to 1 without a clock edge.
REQ-037 Build without LED_SCAN_BLANKING_EN -> ena=1 continuously and frame_done pulses every 20 cycles.
